// File: rtl/ram_initiator.sv
// Request/response front end for a registered single-port RAM, with a
// background sequential scan reader that yields to host traffic.
module ram_initiator #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned SCAN_DIV = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic              scan_en,
  output logic              rsp_valid,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_scan,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int unsigned CntW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StWait} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              src_q, src_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_scan_q, rsp_scan_d;
  logic              accept, scan_issue;

  assign req_ready  = (state_q == StIdle) && reset;
  assign ram_we     = (state_q == StWrite) && reset;
  assign ram_addr   = addr_q;
  assign ram_din    = data_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_addr   = rsp_addr_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_scan   = rsp_scan_q;

  assign accept     = req_valid && req_ready;
  // Host traffic always wins; a scan only goes out on an otherwise empty idle cycle.
  assign scan_issue = (state_q == StIdle) && pend_q && !req_valid;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    src_d       = src_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    rsp_valid_d = 1'b0;
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;
    rsp_scan_d  = rsp_scan_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d  = req_addr;
          data_d  = req_data;
          src_d   = 1'b0;
          state_d = req_we ? StWrite : StRead;
        end else if (scan_issue) begin
          addr_d  = ptr_q;
          src_d   = 1'b1;
          ptr_d   = ptr_q + 1'b1;
          state_d = StRead;
        end
      end
      StWrite: state_d = StIdle;
      StRead:  state_d = StWait;
      StWait: begin
        state_d     = StIdle;
        rsp_valid_d = 1'b1;
        rsp_addr_d  = addr_q;
        rsp_data_d  = ram_dout;
        rsp_scan_d  = src_q;
      end
      default: state_d = StIdle;
    endcase

    // A new trigger on the issuing edge re-arms pending rather than being lost.
    if (!scan_en) begin
      cnt_d  = '0;
      pend_d = 1'b0;
    end else begin
      if (scan_issue) pend_d = 1'b0;
      if (cnt_q == CntMax) begin
        cnt_d  = '0;
        pend_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      data_q      <= '0;
      src_q       <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
      rsp_scan_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      src_q       <= src_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_scan_q  <= rsp_scan_d;
    end
  end

endmodule

// File: tb/tb_ram_initiator.sv
// Scoreboard bench for ram_initiator: a driver pushes expected read responses,
// a negedge monitor pops and compares them as rsp_valid strobes appear.
module tb_ram_initiator;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [4:0] req_addr = '0;
  logic [3:0] req_data = '0;
  logic       scan_en = 1'b0;
  logic       rsp_valid;
  logic [4:0] rsp_addr;
  logic [3:0] rsp_data;
  logic       rsp_scan;
  logic [4:0] ram_addr;
  logic [3:0] ram_din;
  logic       ram_we;
  logic [3:0] ram_dout;

  ram_initiator #(.ADDR_W(5), .DATA_W(4), .SCAN_DIV(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_data(req_data), .scan_en(scan_en),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_scan(rsp_scan),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Registered-address RAM: q reflects the address sampled on the previous edge.
  logic [3:0] ram_mem [32];
  logic [3:0] init_pat [32];
  logic [3:0] model_mem [32];
  logic       ram_init_done = 1'b0;
  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 32; i++) ram_mem[i] <= init_pat[i];
    end else begin
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      ram_dout <= ram_mem[ram_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0] addr;
    logic [3:0] data;
    logic       scan;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int last_scan_cyc = -1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_addr", int'(rsp_addr), int'(e.addr));
        check("rsp_data", int'(rsp_data), int'(e.data));
        check("rsp_scan", int'(rsp_scan), int'(e.scan));
        if (e.cyc >= 0) check("rsp_latency", cyc, e.cyc);
        if (e.scan) begin
          if (last_scan_cyc >= 0) check("scan_interval", cyc - last_scan_cyc, 8);
          last_scan_cyc = cyc;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance, or after
  // req_ready comes back when measure is set.
  task automatic host_req(input logic we, input logic [4:0] a, input logic [3:0] d,
                          input bit push, input bit measure);
    bit ok = 0;
    int acc;
    int n;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_data  = d;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    if (!we && push) sb.push_back('{addr: a, data: model_mem[a], scan: 1'b0, cyc: acc + 2});
    @(negedge clk);
    req_valid = 1'b0;
    if (measure) begin
      n = 0;
      while (!req_ready && n < 10) begin
        n++;
        @(negedge clk);
      end
      check(we ? "busy_write" : "busy_read", n, we ? 1 : 2);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [3:0] d);
    host_req(1'b1, a, d, 1'b0, 1'b1);
    model_mem[a] = d;
  endtask

  task automatic rd(input logic [4:0] a);
    host_req(1'b0, a, 4'd0, 1'b1, 1'b1);
  endtask

  task automatic wait_drain(input int lim);
    for (int i = 0; i < lim && sb.size() != 0; i++) @(negedge clk);
    check("drain_left", sb.size(), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req_ready"}, int'(req_ready), 0);
    check({tag, "_ram_we"}, int'(ram_we), 0);
    check({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    check({tag, "_rsp_addr"}, int'(rsp_addr), 0);
    check({tag, "_rsp_data"}, int'(rsp_data), 0);
    check({tag, "_rsp_scan"}, int'(rsp_scan), 0);
    check({tag, "_ram_addr"}, int'(ram_addr), 0);
    check({tag, "_ram_din"}, int'(ram_din), 0);
  endtask

  initial begin
    logic [4:0] wa [5];
    logic [3:0] wd [5];
    wa = '{5'd25, 5'd13, 5'd27, 5'd1, 5'd6};
    wd = '{4'd9, 4'd4, 4'd5, 4'd11, 4'd15};
    for (int i = 0; i < 32; i++) begin
      init_pat[i]  = 4'($urandom_range(15));
      model_mem[i] = init_pat[i];
    end

    // Reset state
    repeat (3) @(negedge clk);
    ram_init_done = 1'b1;
    check_zero_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", int'(req_ready), 1);

    // Write then read
    wr(5'd17, 4'd10);
    rd(5'd17);
    wait_drain(20);

    // Back-to-back writes, then reads in order
    for (int i = 0; i < 5; i++) wr(wa[i], wd[i]);
    for (int i = 0; i < 5; i++) rd(wa[i]);
    wait_drain(20);

    // Reset during WRITE suppresses the RAM update
    host_req(1'b1, 5'd6, 4'd3, 1'b0, 1'b0);
    reset = 1'b0;
    #1 check("midwrite_ram_we", int'(ram_we), 0);
    @(negedge clk);
    check("midwrite_ram_we_edge", int'(ram_we), 0);
    reset = 1'b1;
    @(negedge clk);
    rd(5'd6);
    wait_drain(20);

    // Reset during WAIT abandons the read
    host_req(1'b0, 5'd9, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_zero_outputs("midread");
    reset = 1'b1;
    @(negedge clk);
    check("midread_ready", int'(req_ready), 1);

    // Free-running scan: 0..31 then wrap to 0
    last_scan_cyc = -1;
    for (int i = 0; i < 33; i++) begin
      logic [4:0] p;
      p = 5'(i);
      sb.push_back('{addr: p, data: model_mem[p], scan: 1'b1, cyc: -1});
    end
    scan_en = 1'b1;
    wait_drain(400);
    scan_en = 1'b0;
    repeat (12) @(negedge clk);

    // Host read beats a pending scan, which still happens afterwards
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    last_scan_cyc = -1;
    scan_en = 1'b1;
    repeat (8) @(negedge clk);
    rd(5'd6);
    sb.push_back('{addr: 5'd0, data: model_mem[0], scan: 1'b1, cyc: -1});
    repeat (2) @(negedge clk);
    scan_en = 1'b0;
    wait_drain(20);

    // Random host traffic
    for (int i = 0; i < 60; i++) begin
      logic [4:0] a;
      logic [3:0] d;
      a = 5'($urandom_range(31));
      d = 4'($urandom_range(15));
      if ($urandom_range(1) == 1) wr(a, d);
      else rd(a);
      if ($urandom_range(3) == 0) @(negedge clk);
    end
    wait_drain(20);
    repeat (20) @(negedge clk);
    check("final_queue_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
